// File: rtl/d8_pkg.sv
// Shared definitions for the dumb8 fetch stage: state encoding and default reset PC.
package d8_pkg;

    // Fetch controller states.
    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        FETCH_OP = 3'd1,
        FETCH_A  = 3'd2,
        FULL     = 3'd3,
        DRAIN    = 3'd4
    } d8_state_t;

    // PC value loaded on reset unless the instance overrides it.
    localparam logic [7:0] D8_RESET_PC = 8'h00;

endpackage

// File: rtl/d8_fetch.sv
// dumb8 instruction fetch stage.
// Owns the PC, fetches two-byte instructions (opcode, operand) over a
// req/ack memory port and buffers one instruction for decode. A jump from
// the jump handler retargets the PC and flushes any buffered or partially
// fetched instruction; a request already in flight is drained first.
module d8_fetch
    import d8_pkg::*;
#(
    parameter logic [7:0] RESET_PC = D8_RESET_PC
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       jmp_load,
    input  logic [7:0] jmp_addr,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] instr_op,
    output logic [7:0] instr_a,
    output logic [7:0] instr_pc,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] pc
);

    d8_state_t state;

    // A request is outstanding in every state that talks to memory; decoding
    // it straight from the state register lets reset drop it immediately.
    assign imem_req    = (state == FETCH_OP) || (state == FETCH_A) || (state == DRAIN);
    assign imem_addr   = pc;
    assign instr_valid = (state == FULL);

    // Fetch FSM, PC register and instruction buffer.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            instr_op <= 8'h00;
            instr_a  <= 8'h00;
            instr_pc <= 8'h00;
        end else begin
            case (state)
                // Jumps are ignored here: the core has not started fetching yet.
                BOOT: begin
                    state <= FETCH_OP;
                end

                FETCH_OP: begin
                    if (jmp_load) begin
                        // An ack in this cycle belongs to the old stream and is
                        // dropped; without one the request is still owed to us.
                        pc    <= jmp_addr;
                        state <= imem_ack ? FETCH_OP : DRAIN;
                    end else if (imem_ack) begin
                        instr_op <= imem_data;
                        instr_pc <= pc;
                        pc       <= pc + 8'd1;
                        state    <= FETCH_A;
                    end
                end

                FETCH_A: begin
                    if (jmp_load) begin
                        pc    <= jmp_addr;
                        state <= imem_ack ? FETCH_OP : DRAIN;
                    end else if (imem_ack) begin
                        instr_a <= imem_data;
                        pc      <= pc + 8'd1;
                        state   <= FULL;
                    end
                end

                FULL: begin
                    // A jump coinciding with instr_ready still completes the
                    // transfer to decode; the buffer is simply not refilled
                    // from the old stream.
                    if (jmp_load) begin
                        pc    <= jmp_addr;
                        state <= FETCH_OP;
                    end else if (instr_ready) begin
                        state <= FETCH_OP;
                    end
                end

                DRAIN: begin
                    // Wait out the abandoned request; its data is never used.
                    if (jmp_load) begin
                        pc <= jmp_addr;
                    end
                    if (imem_ack) begin
                        state <= FETCH_OP;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d8_fetch.sv
// Self-checking bench for d8_fetch: behavioural instruction memory with a
// configurable wait, and a scoreboard of instructions expected at decode.
module tb_d8_fetch;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       jmp_load = 1'b0;
    logic [7:0] jmp_addr = 8'h00;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] instr_op;
    logic [7:0] instr_a;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] pc;

    d8_fetch #(.RESET_PC(8'h00)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .jmp_load    (jmp_load),
        .jmp_addr    (jmp_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_op    (instr_op),
        .instr_a     (instr_a),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- memory model ----------------
    // The address is captured when a request starts, so an ack that completes
    // after a redirect returns data from the old address (stale data).
    logic [7:0] mem [256];
    int         delay_cfg = 0;
    int         wait_cnt  = 0;
    logic       busy      = 1'b0;
    logic [7:0] lat_addr  = 8'h00;

    assign imem_ack  = imem_req && (wait_cnt >= delay_cfg);
    assign imem_data = busy ? mem[lat_addr] : mem[imem_addr];

    always @(posedge sys_clk) begin
        if (!imem_req || imem_ack) begin
            busy     <= 1'b0;
            wait_cnt <= 0;
        end else begin
            if (!busy) lat_addr <= imem_addr;
            busy     <= 1'b1;
            wait_cnt <= wait_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] ipc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge sys_clk) begin
        if (sys_rst_n && instr_valid && instr_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got op=%h a=%h pc=%h, expected no transfer",
                         instr_op, instr_a, instr_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({instr_op, instr_a, instr_pc} !== e) begin
                    n_fail++;
                    $display("FAIL sb_instr: got op=%h a=%h pc=%h, expected op=%h a=%h pc=%h",
                             instr_op, instr_a, instr_pc, e.op, e.a, e.ipc);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    endtask

    task automatic do_reset();
        sys_rst_n   = 1'b0;
        jmp_load    = 1'b0;
        jmp_addr    = 8'h00;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    // Wait (bounded) for a buffered instruction, register the expectation and
    // hand it to decode with a single-cycle instr_ready pulse.
    task automatic accept_instr(input logic [7:0] op, input logic [7:0] a, input logic [7:0] ipc);
        int waited = 0;
        while (!instr_valid && waited < 40) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!instr_valid) begin
            n_fail++;
            $display("FAIL accept_timeout: got instr_valid=0 after %0d cycles, expected 1", waited);
        end else begin
            exp_t e;
            e.op  = op;
            e.a   = a;
            e.ipc = ipc;
            sb_q.push_back(e);
            instr_ready = 1'b1;
            tick();
            instr_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_checks++;
        if ({imem_req, imem_addr, instr_valid, instr_op, instr_a, instr_pc, pc} !== 42'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b addr=%h vld=%b op=%h a=%h ipc=%h pc=%h, expected all zero",
                     imem_req, imem_addr, instr_valid, instr_op, instr_a, instr_pc, pc);
        end
    endtask

    task automatic test_basic();
        fill_mem();
        mem[0] = 8'h03;
        mem[1] = 8'h42;
        delay_cfg   = 0;
        instr_ready = 1'b1;
        do_reset();
        sb_q.push_back('{op: 8'h03, a: 8'h42, ipc: 8'h00});
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_first_req: got req=%b addr=%h, expected req=1 addr=00", imem_req, imem_addr);
        end
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_op !== 8'h03 || instr_a !== 8'h42 || instr_pc !== 8'h00 || pc !== 8'h02) begin
            n_fail++;
            $display("FAIL basic_cycle3: got vld=%b op=%h a=%h ipc=%h pc=%h, expected vld=1 op=03 a=42 ipc=00 pc=02",
                     instr_valid, instr_op, instr_a, instr_pc, pc);
        end
        tick();
        instr_ready = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_single_valid: got instr_valid=%b, expected 0", instr_valid);
        end
    endtask

    task automatic test_wait_states();
        logic       prev_wait = 1'b0;
        logic [7:0] prev_addr = 8'h00;
        int         waits = 0;
        fill_mem();
        delay_cfg   = 4;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 60 && !instr_valid; i++) begin
            tick();
            if (prev_wait) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL wait_hold: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, prev_addr);
                end
            end
            prev_wait = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (prev_wait) waits++;
        end
        n_checks++;
        if (waits != 8 || pc !== 8'h02) begin
            n_fail++;
            $display("FAIL wait_count: got waits=%0d pc=%h, expected waits=8 pc=02", waits, pc);
        end
        tick();
        accept_instr(mem[0], mem[1], 8'h00);
        delay_cfg = 0;
    endtask

    task automatic test_jump_drain();
        fill_mem();
        mem[1]    = 8'hEE;
        mem[8'h80] = 8'h11;
        mem[8'h81] = 8'h22;
        delay_cfg   = 4;
        instr_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_ack !== 1'b0 || pc !== 8'h01) begin
            n_fail++;
            $display("FAIL drain_setup: got req=%b ack=%b pc=%h, expected req=1 ack=0 pc=01", imem_req, imem_ack, pc);
        end
        jmp_load = 1'b1;
        jmp_addr = 8'h80;
        tick();
        jmp_load = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || pc !== 8'h80 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_enter: got req=%b pc=%h vld=%b, expected req=1 pc=80 vld=0", imem_req, pc, instr_valid);
        end
        delay_cfg = 0;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h80 || pc !== 8'h80) begin
            n_fail++;
            $display("FAIL drain_next_req: got req=%b addr=%h pc=%h, expected req=1 addr=80 pc=80", imem_req, imem_addr, pc);
        end
        accept_instr(8'h11, 8'h22, 8'h80);
    endtask

    task automatic test_full_hold_jump();
        fill_mem();
        delay_cfg   = 0;
        instr_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr_op !== mem[0] || instr_a !== mem[1] || instr_pc !== 8'h00) begin
                n_fail++;
                $display("FAIL full_hold[%0d]: got vld=%b op=%h a=%h ipc=%h, expected vld=1 op=%h a=%h ipc=00",
                         i, instr_valid, instr_op, instr_a, instr_pc, mem[0], mem[1]);
            end
            tick();
        end
        jmp_load = 1'b1;
        jmp_addr = 8'h10;
        tick();
        jmp_load = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h10 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL full_jump: got vld=%b pc=%h req=%b, expected vld=0 pc=10 req=1", instr_valid, pc, imem_req);
        end
        accept_instr(mem[8'h10], mem[8'h11], 8'h10);
    endtask

    task automatic test_wrap();
        fill_mem();
        delay_cfg   = 0;
        instr_ready = 1'b0;
        do_reset();
        jmp_load = 1'b1;
        jmp_addr = 8'h55;
        tick();
        n_checks++;
        if (pc !== 8'h00 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_ignores_jump: got pc=%h req=%b, expected pc=00 req=1", pc, imem_req);
        end
        jmp_addr = 8'hFF;
        tick();
        jmp_load = 1'b0;
        n_checks++;
        if (pc !== 8'hFF || imem_addr !== 8'hFF || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_with_ack: got pc=%h addr=%h vld=%b, expected pc=ff addr=ff vld=0", pc, imem_addr, instr_valid);
        end
        tick();
        n_checks++;
        if (pc !== 8'h00 || imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap_pc: got pc=%h addr=%h, expected pc=00 addr=00", pc, imem_addr);
        end
        tick();
        n_checks++;
        if (pc !== 8'h01 || instr_valid !== 1'b1 || instr_pc !== 8'hFF) begin
            n_fail++;
            $display("FAIL wrap_end: got pc=%h vld=%b ipc=%h, expected pc=01 vld=1 ipc=ff", pc, instr_valid, instr_pc);
        end
        accept_instr(mem[8'hFF], mem[0], 8'hFF);
    endtask

    task automatic test_back_to_back();
        fill_mem();
        delay_cfg   = 0;
        instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.op  = mem[2 * k];
            e.a   = mem[2 * k + 1];
            e.ipc = 8'(2 * k);
            sb_q.push_back(e);
        end
        repeat (10) tick();
        instr_ready = 1'b0;
        n_checks++;
        if (pc !== 8'h06 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput: got pc=%h pending=%0d, expected pc=06 pending=0", pc, sb_q.size());
        end
        repeat (2) tick();
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h06) begin
            n_fail++;
            $display("FAIL b2b_refill: got vld=%b ipc=%h, expected vld=1 ipc=06", instr_valid, instr_pc);
        end
        sb_q.push_back('{op: mem[6], a: mem[7], ipc: 8'h06});
        instr_ready = 1'b1;
        jmp_load    = 1'b1;
        jmp_addr    = 8'h30;
        tick();
        instr_ready = 1'b0;
        jmp_load    = 1'b0;
        n_checks++;
        if (instr_valid !== 1'b0 || pc !== 8'h30 || imem_req !== 1'b1 || imem_addr !== 8'h30 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL jump_full_ready: got vld=%b pc=%h req=%b addr=%h pending=%0d, expected vld=0 pc=30 req=1 addr=30 pending=0",
                     instr_valid, pc, imem_req, imem_addr, sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        fill_mem();
        mem[0] = 8'h03;
        mem[1] = 8'h42;
        delay_cfg   = 0;
        instr_ready = 1'b0;
        do_reset();
        repeat (2) tick();
        n_checks++;
        if (imem_req !== 1'b1 || instr_op !== 8'h03) begin
            n_fail++;
            $display("FAIL rstmid_setup: got req=%b op=%h, expected req=1 op=03", imem_req, instr_op);
        end
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr, instr_valid, instr_op, instr_a, instr_pc, pc} !== 42'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b addr=%h vld=%b op=%h a=%h ipc=%h pc=%h, expected all zero",
                     imem_req, imem_addr, instr_valid, instr_op, instr_a, instr_pc, pc);
        end
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        tick();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_restart: got req=%b addr=%h, expected req=1 addr=00", imem_req, imem_addr);
        end
        accept_instr(8'h03, 8'h42, 8'h00);
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_basic();
        test_wait_states();
        test_jump_drain();
        test_full_hold_jump();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (2) tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d8_fetch.md
# d8_fetch

Instruction fetch stage of the dumb8 core: owns the 8-bit program counter, fetches fixed two-byte instructions (opcode byte, then operand byte) from instruction memory over a req/ack interface, and presents them to decode with a valid/ready handshake. It sits directly downstream of the jump handler. It consumes that block's load strobe and target address to redirect the PC and flush any in-flight or buffered instruction.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- sys_clk  in  1  core clock; all state updates on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- jmp_load  in  1  redirect strobe from the jump handler; sampled each edge.
- jmp_addr  in  8  redirect target; valid when jmp_load=1.
- imem_req  out  1  memory request; held until imem_ack.
- imem_addr  out  8  request address, equal to pc while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_data valid in the same cycle.
- imem_data  in  8  memory read data.
- instr_op  out  8  buffered opcode.
- instr_a  out  8  buffered operand.
- instr_pc  out  8  address of the buffered opcode.
- instr_valid  out  1  buffered instruction available to decode.
- instr_ready  in  1  decode accepts; transfer occurs when instr_valid & instr_ready.
- pc  out  8  current fetch pointer.

## Operation
- States:
  - BOOT: reset state; goes to FETCH_OP on the next edge.
  - FETCH_OP: imem_req=1; on ack, latches instr_op and instr_pc<=pc, then goes to FETCH_A.
  - FETCH_A: imem_req=1; on ack, latches instr_a, then goes to FULL.
  - FULL: instr_valid=1, imem_req=0; on instr_ready, goes to FETCH_OP.
  - DRAIN: imem_req=1; waits for a stale ack, discards the data, then goes to FETCH_OP.
- imem_req is a combinational decode of state (FETCH_OP, FETCH_A, DRAIN). imem_addr=pc.
- pc increments by 1 on every ack accepted in FETCH_OP or FETCH_A. It wraps from 8'hFF to 8'h00; an instruction may straddle the wrap.
- Jump (jmp_load=1) has priority over every other event in every state except BOOT, where it is ignored:
  - next-cycle pc<=jmp_addr and instr_valid<=0; any buffered or partial instruction is dropped.
  - in FETCH_OP or FETCH_A without ack in the same cycle: go to DRAIN, since the outstanding request must complete.
  - in FETCH_OP or FETCH_A with ack in the same cycle: data discarded, no pc increment, go to FETCH_OP.
  - in FULL, even with instr_ready=1 in the same cycle: the transfer still counts as accepted by decode, and the state goes to FETCH_OP.
  - in DRAIN: pc is retargeted to the new jmp_addr; stay in DRAIN unless ack arrives the same cycle, in which case go to FETCH_OP.
- Reset mid-request: state returns to BOOT asynchronously and imem_req drops immediately. Memory must tolerate an abandoned request.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_op=instr_a=instr_pc=8'h00.
- First imem_req is asserted one cycle after reset release.
- Best case is 3 cycles per instruction: one ack cycle each in FETCH_OP and FETCH_A, plus one FULL cycle with instr_ready=1.
- Jump-to-request latency: 1 cycle when no request is outstanding. Otherwise it is 1 cycle plus the remaining memory wait.
- instr_* outputs are stable while instr_valid=1 and instr_ready=0.

## Structure
- d8_pkg holds the state encoding (3-bit enum: BOOT, FETCH_OP, FETCH_A, FULL, DRAIN) and the default RESET_PC constant; these are shared with the decode-stage testbench.
- Single module, no sub-modules. The PC register with its increment and load logic stays inline.

## Test plan
- Reset release with a zero-wait memory returning {0x03,0x42} at addresses 0,1 and instr_ready=1 -> instr_op=0x03, instr_a=0x42, instr_pc=0x00, instr_valid for 1 cycle in cycle 3; pc=0x02.
- Memory ack delayed 4 cycles per request -> imem_req and imem_addr are held constant until ack; instruction is presented with correct bytes; pc advances by exactly 2.
- jmp_load=1 with jmp_addr=0x80 while in FETCH_A with no ack -> DRAIN; the stale ack data never appears on instr_*; the next request address is 0x80.
- Instruction held in FULL with instr_ready=0 for 5 cycles, then jmp_load with target 0x10 -> instr_valid drops the next cycle; the next fetched instr_pc is 0x10.
- Start at pc=0xFF (jump to 0xFF) -> opcode fetched at 0xFF, operand at 0x00, instr_pc=0xFF, pc ends at 0x01.
- Assert sys_rst_n=0 while imem_req=1 -> imem_req=0 immediately and all outputs take their reset values; after release, fetch restarts at RESET_PC.
